// File: rtl/cpu_dma_tx_watchdog.sv
// TX watchdog between CPU DMA and TX FIFO: tracks SOP/EOP framing and aborts stalled packets.
// Optional macro CPU_DMA_TX_WDOG_PAUSE_ON_FULL_EN freezes the idle counter while the TX FIFO is full.
module cpu_dma_tx_watchdog #(
    parameter int unsigned TX_WATCHDOG_TIMEOUT = 125000
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_wr_vld,
    input  logic dma_wr_sop,
    input  logic dma_wr_eop,
    output logic dma_wr_rdy,
    input  logic tx_fifo_full,
    output logic tx_timeout,
    output logic tx_abort,
    input  logic tx_abort_ack,
    output logic proto_err,
    output logic in_pkt
);

    localparam int unsigned CNT_W = $clog2(TX_WATCHDOG_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_WATCHDOG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        ABORT  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_nxt;
    logic             perr_nxt;
    logic             accept;
    logic             cnt_pause;

`ifdef CPU_DMA_TX_WDOG_PAUSE_ON_FULL_EN
    assign cnt_pause = tx_fifo_full;
`else
    assign cnt_pause = 1'b0;
`endif

    assign dma_wr_rdy = !tx_fifo_full && (state != ABORT);
    assign accept     = dma_wr_vld && dma_wr_rdy;
    assign tx_abort   = (state == ABORT);
    assign in_pkt     = (state == IN_PKT);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        perr_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    if (!dma_wr_sop)
                        perr_nxt = 1'b1;
                    else if (!dma_wr_eop)
                        state_nxt = IN_PKT;
                end
            end
            IN_PKT: begin
                if (accept) begin
                    cnt_nxt  = '0;
                    perr_nxt = dma_wr_sop;
                    if (dma_wr_eop)
                        state_nxt = IDLE;
                end else if (!cnt_pause) begin
                    // An accepted word in the expiry cycle takes the branch above, so EOP wins.
                    if (cnt == CNT_LAST) begin
                        state_nxt   = ABORT;
                        timeout_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ABORT: begin
                cnt_nxt = '0;
                if (tx_abort_ack)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_timeout <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            tx_timeout <= timeout_nxt;
            proto_err  <= perr_nxt;
        end
    end

endmodule
